vz_image_loader: RTL and testbench

- Streams a VZ snapshot from the HPS download channel into Laser310 system RAM through an arbitrated RAM write port.
- Parses the 24-byte VZ header, buffers payload bytes in a small FIFO, and back-pressures the HPS with dn_wait.
- After a BASIC image, patches the end-of-program pointer.
- Sits between hps_io's ioctl outputs and the LASER310_TOP RAM arbiter.

---
 rtl/vz_image_loader.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_vz_image_loader.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vz_image_loader.sv
// vz_image_loader
// Streams a VZ snapshot from the HPS ioctl download channel into system RAM
// through an arbitrated write port. It parses the 24-byte header, buffers
// payload bytes in a small FIFO and back-pressures the HPS with dn_wait.
// After a BASIC image it patches the end-of-BASIC pointer.
// Optional build macro: VZ_AUTORUN_EN adds exec_req/exec_addr for binary autorun.
module vz_image_loader #(
  parameter int unsigned ADDR_W        = 16,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter logic [7:0]  FILE_INDEX    = 8'd1,
  parameter int unsigned HDR_LEN       = 24,
  parameter logic [15:0] BASIC_END_PTR = 16'h78F9
) (
  input  logic              clk_sys,
  input  logic              RESET,
  input  logic              dn_download,
  input  logic [7:0]        dn_index,
  input  logic [15:0]       dn_addr,
  input  logic [7:0]        dn_data,
  input  logic              dn_wr,
  output logic              dn_wait,
  output logic              ram_req,
  input  logic              ram_ack,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_dout,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [7:0]        file_type
`ifdef VZ_AUTORUN_EN
  ,
  output logic              exec_req,
  output logic [15:0]       exec_addr
`endif
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_DATA,
    S_DRAIN,
    S_PATCH_LO,
    S_PATCH_HI,
    S_DONE,
    S_ERROR
  } state_t;

  state_t r_state;
  state_t w_next;

  logic              r_active_q;
  logic              w_active;
  logic              w_start;
  logic              w_wr;
  logic              w_hdr_wr;
  logic              w_magic_bad;
  logic              w_hdr_last;
  logic              w_data_wr;
  logic              w_full;
  logic              w_push;
  logic              w_overflow;
  logic              w_pop;
  logic              w_flush;

  logic [15:0]       r_start;
  logic [15:0]       r_len;
  logic [7:0]        r_file_type;
  logic              r_done;
  logic              r_error;
  logic              r_req;

  logic [ADDR_W-1:0] r_fifo_addr [FIFO_DEPTH];
  logic [7:0]        r_fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;

  logic [15:0]       w_offs;
  logic [15:0]       w_sum16;
  logic [ADDR_W-1:0] w_push_addr;
  logic [ADDR_W-1:0] w_head_addr;
  logic [7:0]        w_head_data;
  logic [15:0]       w_end;

  assign w_active    = dn_download && (dn_index == FILE_INDEX);
  assign w_start     = w_active && !r_active_q;
  assign w_wr        = dn_wr && w_active;

  assign w_hdr_wr    = w_wr && (r_state == S_HEADER);
  assign w_magic_bad = w_hdr_wr &&
                       (((dn_addr == 16'd0) && (dn_data != 8'h56)) ||
                        ((dn_addr == 16'd1) && (dn_data != 8'h5A)) ||
                        ((dn_addr == 16'd2) && (dn_data != 8'h46)));
  assign w_hdr_last  = w_hdr_wr && (dn_addr == 16'(HDR_LEN - 1));

  assign w_data_wr   = w_wr && (r_state == S_DATA);
  assign w_full      = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_push      = w_data_wr && !w_full;
  assign w_overflow  = w_data_wr && w_full;
  assign w_pop       = r_req && ram_ack &&
                       ((r_state == S_DATA) || (r_state == S_DRAIN));
  assign w_flush     = w_start || (w_next == S_ERROR);

  assign w_offs      = dn_addr - 16'(HDR_LEN);
  assign w_sum16     = r_start + w_offs;
  assign w_push_addr = ADDR_W'(w_sum16);
  assign w_head_addr = r_fifo_addr[r_rptr];
  assign w_head_data = r_fifo_data[r_rptr];
  assign w_end       = r_start + r_len;

  assign dn_wait     = (r_count >= CNT_W'(FIFO_DEPTH - 1));
  assign done        = r_done;
  assign error       = r_error;
  assign file_type   = r_file_type;

  // State register and load-start edge detector
  always_ff @(posedge clk_sys or negedge RESET) begin
    if (!RESET) begin
      r_state    <= S_IDLE;
      r_active_q <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_active_q <= w_active;
    end
  end

  // Next-state decode and RAM port / status outputs
  always_comb begin
    w_next   = r_state;
    busy     = 1'b0;
    ram_req  = 1'b0;
    ram_addr = '0;
    ram_dout = '0;
`ifdef VZ_AUTORUN_EN
    exec_req = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
      end
      S_HEADER: begin
        busy = 1'b1;
        if (!w_active || w_magic_bad) begin
          w_next = S_ERROR;
        end else if (w_hdr_last) begin
          w_next = S_DATA;
        end
      end
      S_DATA: begin
        busy = 1'b1;
        if (r_req) begin
          ram_req  = 1'b1;
          ram_addr = w_head_addr;
          ram_dout = w_head_data;
        end
        if (w_overflow) begin
          w_next = S_ERROR;
        end else if (!w_active) begin
          w_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (r_req) begin
          ram_req  = 1'b1;
          ram_addr = w_head_addr;
          ram_dout = w_head_data;
        end
        if (r_count == '0) begin
          w_next = (r_file_type == 8'hF0) ? S_PATCH_LO : S_DONE;
        end
      end
      S_PATCH_LO: begin
        busy     = 1'b1;
        ram_req  = 1'b1;
        ram_addr = ADDR_W'(BASIC_END_PTR);
        ram_dout = w_end[7:0];
        if (ram_ack) begin
          w_next = S_PATCH_HI;
        end
      end
      S_PATCH_HI: begin
        busy     = 1'b1;
        ram_req  = 1'b1;
        ram_addr = ADDR_W'(BASIC_END_PTR + 16'd1);
        ram_dout = w_end[15:8];
        if (ram_ack) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
`ifdef VZ_AUTORUN_EN
        exec_req = (r_file_type == 8'hF1);
`endif
        w_next = S_IDLE;
      end
      S_ERROR: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
    // A fresh load start overrides whatever the FSM was doing.
    if (w_start) begin
      w_next = S_HEADER;
    end
  end

`ifdef VZ_AUTORUN_EN
  assign exec_addr = r_start;
`endif

  // Header field capture, payload length and sticky status flags
  always_ff @(posedge clk_sys or negedge RESET) begin
    if (!RESET) begin
      r_start     <= '0;
      r_len       <= '0;
      r_file_type <= '0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      if (w_start) begin
        r_len   <= '0;
        r_done  <= 1'b0;
        r_error <= 1'b0;
      end else begin
        if (w_push) begin
          r_len <= r_len + 16'd1;
        end
        if (w_next == S_DONE) begin
          r_done <= 1'b1;
        end
        if (w_next == S_ERROR) begin
          r_error <= 1'b1;
        end
      end
      if (w_hdr_wr) begin
        if (dn_addr == 16'd21) begin
          r_file_type <= dn_data;
        end
        if (dn_addr == 16'd22) begin
          r_start[7:0] <= dn_data;
        end
        if (dn_addr == 16'd23) begin
          r_start[15:8] <= dn_data;
        end
      end
    end
  end

  // FIFO pointers, occupancy and the registered write request
  // r_req follows a non-empty FIFO one cycle late and drops for the cycle after
  // each pop, so ram_req only rises once the new head has settled.
  always_ff @(posedge clk_sys or negedge RESET) begin
    if (!RESET) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_req   <= 1'b0;
    end else if (w_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_req   <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      r_req <= (r_count != '0) && !w_pop;
    end
  end

  // FIFO storage (payload address and byte)
  always_ff @(posedge clk_sys) begin
    if (w_push) begin
      r_fifo_addr[r_wptr] <= w_push_addr;
      r_fifo_data[r_wptr] <= dn_data;
    end
  end

endmodule

// File: tb/tb_vz_image_loader.sv
// Testbench for vz_image_loader: table-driven loads, randomized loads against
// a write-list reference model, and hand sequences for back-pressure,
// FIFO overflow, asynchronous reset and foreign download indices.
module tb_vz_image_loader;

  logic        clk_sys = 1'b0;
  logic        RESET = 1'b0;
  logic        dn_download = 1'b0;
  logic [7:0]  dn_index = 8'd0;
  logic [15:0] dn_addr = 16'd0;
  logic [7:0]  dn_data = 8'd0;
  logic        dn_wr = 1'b0;
  logic        dn_wait;
  logic        ram_req;
  logic        ram_ack = 1'b0;
  logic [15:0] ram_addr;
  logic [7:0]  ram_dout;
  logic        busy;
  logic        done;
  logic        error;
  logic [7:0]  file_type;
`ifdef VZ_AUTORUN_EN
  logic        exec_req;
  logic [15:0] exec_addr;
`endif

  vz_image_loader #(
    .ADDR_W(16),
    .FIFO_DEPTH(4),
    .FILE_INDEX(8'd1),
    .HDR_LEN(24),
    .BASIC_END_PTR(16'h78F9)
  ) dut (
    .clk_sys(clk_sys),
    .RESET(RESET),
    .dn_download(dn_download),
    .dn_index(dn_index),
    .dn_addr(dn_addr),
    .dn_data(dn_data),
    .dn_wr(dn_wr),
    .dn_wait(dn_wait),
    .ram_req(ram_req),
    .ram_ack(ram_ack),
    .ram_addr(ram_addr),
    .ram_dout(ram_dout),
    .busy(busy),
    .done(done),
    .error(error),
    .file_type(file_type)
`ifdef VZ_AUTORUN_EN
    ,
    .exec_req(exec_req),
    .exec_addr(exec_addr)
`endif
  );

  always #5 clk_sys = ~clk_sys;

  int n_cmp = 0;
  int n_bad = 0;
  int ack_mode = 0;  // 0: ack tied high, 1: random ack, 2: ack held low

  logic [15:0] log_addr[$];
  logic [7:0]  log_data[$];
  logic [15:0] exp_addr[$];
  logic [7:0]  exp_data[$];
  logic [7:0]  pay[$];
  int          req_cycles = 0;
  int          exec_pulses = 0;
  logic [15:0] exec_last = 16'd0;

  typedef struct {
    logic [7:0]  ftype;
    logic [15:0] start;
    int          len;
    int          bad_idx;
    int          trunc_at;
    bit          exp_done;
    bit          exp_err;
    int          exp_wr;
    bit          has_ptr;
    logic [15:0] ptr;
  } vec_t;

  vec_t tbl[8];

  // RAM grant generator, changes just after the rising edge
  always @(posedge clk_sys) begin
    #1;
    case (ack_mode)
      0:       ram_ack = 1'b1;
      1:       ram_ack = 1'($urandom_range(0, 1));
      default: ram_ack = 1'b0;
    endcase
  end

  // RAM write monitor, sampled on the falling edge
  always @(negedge clk_sys) begin
    if (ram_req) req_cycles++;
    if (ram_req && ram_ack) begin
      log_addr.push_back(ram_addr);
      log_data.push_back(ram_dout);
    end
`ifdef VZ_AUTORUN_EN
    if (exec_req) begin
      exec_pulses++;
      exec_last = exec_addr;
    end
`endif
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_logs();
    log_addr.delete();
    log_data.delete();
    req_cycles = 0;
    exec_pulses = 0;
  endtask

  task automatic send_byte(input logic [15:0] a, input logic [7:0] d, input bit honour);
    int n = 0;
    while (honour && dn_wait && n < 200) begin
      dn_wr = 1'b0;
      @(negedge clk_sys);
      n++;
    end
    if (n >= 200) begin
      n_cmp++;
      n_bad++;
      $display("FAIL dn_wait_bound: dn_wait still 1 after %0d cycles, expected release", n);
    end
    dn_addr = a;
    dn_data = d;
    dn_wr   = 1'b1;
    @(negedge clk_sys);
    dn_wr   = 1'b0;
  endtask

  function automatic logic [7:0] hdr_byte(input int i, input logic [7:0] ft, input logic [15:0] st);
    case (i)
      0:       return 8'h56;
      1:       return 8'h5A;
      2:       return 8'h46;
      21:      return ft;
      22:      return st[7:0];
      23:      return st[15:8];
      default: return 8'(8'h30 + i);
    endcase
  endfunction

  task automatic start_load(input logic [7:0] idx);
    dn_index    = idx;
    dn_download = 1'b1;
    @(negedge clk_sys);
    @(negedge clk_sys);
  endtask

  task automatic send_header(input logic [7:0] ft, input logic [15:0] st, input int bad, input int trunc);
    for (int i = 0; i < 24; i++) begin
      logic [7:0] b;
      if (i == trunc) return;
      b = hdr_byte(i, ft, st);
      if (i == bad) b = 8'h58;
      send_byte(16'(i), b, 1'b1);
    end
  endtask

  task automatic end_load();
    int n = 0;
    dn_download = 1'b0;
    do begin
      @(negedge clk_sys);
      n++;
    end while (busy && n < 400);
    if (busy) begin
      n_cmp++;
      n_bad++;
      $display("FAIL busy_bound: busy still 1 after %0d cycles, expected 0", n);
    end
    @(negedge clk_sys);
  endtask

  // Reference: payload lands at start+i (mod 64K) in order; BASIC then writes
  // the 16-bit end address little-endian at 0x78F9/0x78FA.
  task automatic build_model(input logic [7:0] ft, input logic [15:0] st, input bit ok);
    logic [15:0] e;
    exp_addr.delete();
    exp_data.delete();
    if (!ok) return;
    for (int i = 0; i < pay.size(); i++) begin
      exp_addr.push_back(st + 16'(i));
      exp_data.push_back(pay[i]);
    end
    if (ft == 8'hF0) begin
      e = st + 16'(pay.size());
      exp_addr.push_back(16'h78F9);
      exp_data.push_back(e[7:0]);
      exp_addr.push_back(16'h78FA);
      exp_data.push_back(e[15:8]);
    end
  endtask

  task automatic compare_log(input string tag);
    int n;
    check({tag, "_nwrites"}, 32'(log_addr.size()), 32'(exp_addr.size()));
    n = (log_addr.size() < exp_addr.size()) ? log_addr.size() : exp_addr.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_addr%0d", tag, i), 32'(log_addr[i]), 32'(exp_addr[i]));
      check($sformatf("%s_data%0d", tag, i), 32'(log_data[i]), 32'(exp_data[i]));
    end
  endtask

  task automatic run_case(input vec_t v, input string tag);
    bit ok;
    ok = (v.bad_idx < 0) && (v.trunc_at < 0);
    clear_logs();
    pay.delete();
    for (int i = 0; i < v.len; i++) pay.push_back(8'($urandom));
    start_load(8'd1);
    send_header(v.ftype, v.start, v.bad_idx, v.trunc_at);
    if (v.trunc_at < 0) begin
      for (int i = 0; i < v.len; i++) send_byte(16'(24 + i), pay[i], 1'b1);
    end
    end_load();
    check({tag, "_done"}, 32'(done), 32'(v.exp_done));
    check({tag, "_error"}, 32'(error), 32'(v.exp_err));
    check({tag, "_nwr_rule"}, 32'(log_addr.size()), 32'(v.exp_wr));
    build_model(v.ftype, v.start, ok);
    compare_log(tag);
    if (v.exp_done) check({tag, "_ftype"}, 32'(file_type), 32'(v.ftype));
    if (v.exp_err) check({tag, "_no_req"}, 32'(req_cycles), 32'd0);
    if (v.has_ptr && log_addr.size() >= 2) begin
      check({tag, "_ptr_lo"}, {log_addr[log_addr.size()-2], 8'h00, log_data[log_data.size()-2]},
            {16'h78F9, 8'h00, v.ptr[7:0]});
      check({tag, "_ptr_hi"}, {log_addr[log_addr.size()-1], 8'h00, log_data[log_data.size()-1]},
            {16'h78FA, 8'h00, v.ptr[15:8]});
    end
`ifdef VZ_AUTORUN_EN
    check({tag, "_exec_pulses"}, 32'(exec_pulses), (v.exp_done && v.ftype == 8'hF1) ? 32'd1 : 32'd0);
    if (exec_pulses == 1) check({tag, "_exec_addr"}, 32'(exec_last), 32'(v.start));
`endif
  endtask

  initial begin
    //             ftype  start     len bad trunc done err wr ptr? ptr
    tbl[0] = '{8'hF0, 16'h7AE9, 10, -1, -1, 1'b1, 1'b0, 12, 1'b1, 16'h7AF3};
    tbl[1] = '{8'hF1, 16'hFFFE,  4, -1, -1, 1'b1, 1'b0,  4, 1'b0, 16'h0000};
    tbl[2] = '{8'hF0, 16'h1234,  5,  1, -1, 1'b0, 1'b1,  0, 1'b0, 16'h0000};
    tbl[3] = '{8'hF0, 16'h1234,  5, -1, 10, 1'b0, 1'b1,  0, 1'b0, 16'h0000};
    tbl[4] = '{8'hF0, 16'h8000,  0, -1, -1, 1'b1, 1'b0,  2, 1'b1, 16'h8000};
    tbl[5] = '{8'hF1, 16'h0000,  0, -1, -1, 1'b1, 1'b0,  0, 1'b0, 16'h0000};
    tbl[6] = '{8'hF0, 16'hFFFF,  3, -1, -1, 1'b1, 1'b0,  5, 1'b1, 16'h0002};
    tbl[7] = '{8'hF1, 16'h4000,  6,  0, -1, 1'b0, 1'b1,  0, 1'b0, 16'h0000};

    // Reset state
    RESET = 1'b0;
    repeat (3) @(negedge clk_sys);
    check("rst_flags", {27'd0, ram_req, busy, done, error, dn_wait}, 32'd0);
    check("rst_addr", 32'(ram_addr), 32'd0);
    check("rst_dout_ftype", {16'd0, ram_dout, file_type}, 32'd0);
    RESET = 1'b1;
    @(negedge clk_sys);

    // Table-driven loads, ram_ack tied high
    ack_mode = 0;
    for (int t = 0; t < 8; t++) run_case(tbl[t], $sformatf("tbl%0d", t));

    // Back-pressure: ack held low for 20 cycles during DATA
    begin
      vec_t v;
      clear_logs();
      pay.delete();
      for (int i = 0; i < 8; i++) pay.push_back(8'($urandom));
      ack_mode = 2;
      start_load(8'd1);
      send_header(8'hF1, 16'h5000, -1, -1);
      send_byte(16'd24, pay[0], 1'b1);
      send_byte(16'd25, pay[1], 1'b1);
      check("bp_wait_at2", 32'(dn_wait), 32'd0);
      send_byte(16'd26, pay[2], 1'b1);
      check("bp_wait_at3", 32'(dn_wait), 32'd1);
      repeat (17) @(negedge clk_sys);
      check("bp_wait_hold", 32'(dn_wait), 32'd1);
      check("bp_no_writes", 32'(log_addr.size()), 32'd0);
      ack_mode = 0;
      for (int i = 3; i < 8; i++) send_byte(16'(24 + i), pay[i], 1'b1);
      end_load();
      check("bp_done", 32'(done), 32'd1);
      check("bp_error", 32'(error), 32'd0);
      build_model(8'hF1, 16'h5000, 1'b1);
      compare_log("bp");
      v = tbl[0];
    end

    // Overflow: HPS ignores dn_wait, fifth byte hits a full FIFO
    clear_logs();
    ack_mode = 2;
    start_load(8'd1);
    send_header(8'hF0, 16'h6000, -1, -1);
    for (int i = 0; i < 5; i++) send_byte(16'(24 + i), 8'(8'hA0 + i), 1'b0);
    check("ovf_error_now", 32'(error), 32'd1);
    check("ovf_req_dropped", 32'(ram_req), 32'd0);
    ack_mode = 0;
    end_load();
    check("ovf_done", 32'(done), 32'd0);
    check("ovf_error", 32'(error), 32'd1);
    check("ovf_no_writes", 32'(log_addr.size()), 32'd0);

    // Asynchronous reset in DATA with two queued entries
    clear_logs();
    ack_mode = 2;
    start_load(8'd1);
    send_header(8'hF1, 16'h3000, -1, -1);
    send_byte(16'd24, 8'h11, 1'b1);
    send_byte(16'd25, 8'h22, 1'b1);
    @(negedge clk_sys);
    check("rstm_pre_req", 32'(ram_req), 32'd1);
    check("rstm_pre_busy", 32'(busy), 32'd1);
    #2;
    RESET = 1'b0;
    #1;
    check("rstm_req", 32'(ram_req), 32'd0);
    check("rstm_busy", 32'(busy), 32'd0);
    check("rstm_wait", 32'(dn_wait), 32'd0);
    dn_download = 1'b0;
    @(negedge clk_sys);
    RESET = 1'b1;
    ack_mode = 0;
    @(negedge clk_sys);
    run_case(tbl[0], "after_rst");

    // Foreign download index is ignored entirely
    clear_logs();
    start_load(8'd2);
    send_header(8'hF0, 16'h7000, -1, -1);
    send_byte(16'd24, 8'h55, 1'b1);
    check("foreign_busy", 32'(busy), 32'd0);
    end_load();
    check("foreign_no_req", 32'(req_cycles), 32'd0);
    check("foreign_done_kept", 32'(done), 32'd1);

    // Randomized loads with random RAM grants
    ack_mode = 1;
    for (int r = 0; r < 12; r++) begin
      vec_t v;
      v.ftype    = ($urandom_range(0, 1) == 0) ? 8'hF0 : 8'hF1;
      v.start    = 16'($urandom);
      v.len      = int'($urandom_range(0, 12));
      v.bad_idx  = -1;
      v.trunc_at = -1;
      v.exp_done = 1'b1;
      v.exp_err  = 1'b0;
      v.exp_wr   = v.len + ((v.ftype == 8'hF0) ? 2 : 0);
      v.has_ptr  = (v.ftype == 8'hF0);
      v.ptr      = v.start + 16'(v.len);
      run_case(v, $sformatf("rnd%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
